// File: rtl/dm_banked_ctrl.sv
// dm_banked_ctrl
//   Handshaked data memory for the pipelined MIPS core. It sits between the
//   MEM stage and the bridge and accepts one request at a time. The read and
//   write latency is configurable. Stores use byte enables for word, half and
//   byte accesses. Loads are sign- or zero-extended. Misaligned or
//   out-of-range accesses raise AdEL (loads) or AdES (stores). After every
//   reset a hardware sweep writes zero to each word of the array.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : asynchronous, active-low; low forces INIT immediately
//   req_valid  : request present
//   req_ready  : a request is taken on an edge where req_valid && req_ready
//   req_we     : 1 = store, 0 = load
//   req_type   : 000 word, 001 lh, 010 lhu, 011 lb, 100 lbu (others = word)
//   req_addr   : byte address
//   req_wdata  : right-aligned store data
//   req_pc     : PC of the issuing instruction
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : extended load data (0 for stores, faults, idle cycles)
//   exc_valid  : response carries an address exception
//   exc_code   : 4 = AdEL, 5 = AdES
//   exc_pc     : req_pc of the faulting request
//   busy       : init sweep in progress
module dm_banked_ctrl #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        busy
);

    localparam int unsigned      IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [1:0]       LAT_LOAD = 2'(LATENCY - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lat_cnt_q, lat_cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             exc_q, exc_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic [31:0]      exc_pc_q, exc_pc_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             is_half, is_byte, is_signed;
    logic [31:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             misaligned, out_of_range, fault, accept;
    logic [31:0]      rd_word, load_ext, wr_data;
    logic [3:0]       wr_be;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;

    // Decode the access size and request classification.
    always_comb begin
        is_half   = 1'b0;
        is_byte   = 1'b0;
        is_signed = 1'b0;
        case (req_type)
            3'b001:  begin is_half = 1'b1; is_signed = 1'b1; end
            3'b010:  is_half = 1'b1;
            3'b011:  begin is_byte = 1'b1; is_signed = 1'b1; end
            3'b100:  is_byte = 1'b1;
            default: ;
        endcase

        // The word offset is computed at full width so that an address far
        // beyond the array cannot alias onto a valid index.
        word_off     = (req_addr - BASE_ADDR) >> 2;
        idx          = word_off[IDX_W-1:0];
        out_of_range = (req_addr < BASE_ADDR) || (word_off >= 32'(DEPTH_WORDS));
        misaligned   = is_byte ? 1'b0 : (is_half ? req_addr[0] : (req_addr[1:0] != 2'b00));
        fault        = out_of_range || misaligned;
        accept       = req_valid && req_ready;
    end

    // Load path: the word is read in the accept cycle. A store committed on
    // an earlier edge is therefore always visible.
    always_comb begin
        rd_word  = fault ? 32'h0 : mem[idx];
        byte_val = rd_word[{req_addr[1:0], 3'b000} +: 8];
        half_val = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        if (is_byte)
            load_ext = {{24{is_signed & byte_val[7]}}, byte_val};
        else if (is_half)
            load_ext = {{16{is_signed & half_val[15]}}, half_val};
        else
            load_ext = rd_word;
    end

    // Store path: replicate the right-aligned data across the lanes and
    // enable only the lanes the access touches.
    always_comb begin
        if (is_byte) begin
            wr_data = {4{req_wdata[7:0]}};
            wr_be   = 4'b0001 << req_addr[1:0];
        end else if (is_half) begin
            wr_data = {2{req_wdata[15:0]}};
            wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            wr_data = req_wdata;
            wr_be   = 4'b1111;
        end
    end

    // The array has no reset. The sweep clears it one word per cycle while
    // in INIT. This also runs harmlessly on word 0 while reset is held low.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q] <= 32'h0;
        end else if (accept && req_we && !fault) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) mem[idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // Next-state logic. An accept in WAIT (when lat_cnt has reached zero)
    // overrides the return to IDLE. This gives back-to-back throughput.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_cnt_d  = lat_cnt_q;
        rdata_d    = rdata_q;
        exc_d      = exc_q;
        exc_code_d = exc_code_q;
        exc_pc_d   = exc_pc_q;

        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q != 2'd0) lat_cnt_d = lat_cnt_q - 2'd1;
                else                   state_d   = ST_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            state_d    = ST_WAIT;
            lat_cnt_d  = LAT_LOAD;
            exc_d      = fault;
            exc_code_d = req_we ? 5'd5 : 5'd4;
            exc_pc_d   = fault ? req_pc : 32'h0;
            rdata_d    = (fault || req_we) ? 32'h0 : load_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            lat_cnt_q  <= 2'd0;
            rdata_q    <= 32'h0;
            exc_q      <= 1'b0;
            exc_code_q <= 5'd0;
            exc_pc_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            rdata_q    <= rdata_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
            exc_pc_q   <= exc_pc_d;
        end
    end

    // The response fields are gated so that they read zero outside the
    // response cycle.
    always_comb begin
        busy      = (state_q == ST_INIT);
        rsp_valid = (state_q == ST_WAIT) && (lat_cnt_q == 2'd0);
        req_ready = (state_q == ST_IDLE) || rsp_valid;
        rsp_rdata = rsp_valid ? rdata_q : 32'h0;
        exc_valid = rsp_valid && exc_q;
        exc_code  = exc_valid ? exc_code_q : 5'd0;
        exc_pc    = exc_valid ? exc_pc_q : 32'h0;
    end

endmodule

// File: doc/dm_banked_ctrl.md
# dm_banked_ctrl

Parametrised data-memory controller for the pipelined MIPS core. It replaces a combinational-read memory with a handshaked one that has a configurable read/write latency. It supports word, half and byte stores through per-lane byte enables, and sign or zero extension on loads. It raises AdEL/AdES for misaligned or out-of-range accesses, and clears its array with a hardware init sweep after reset. It sits between the MEM stage and the bridge, one outstanding request at a time.

## Interface
- DEPTH_WORDS, 3072: number of 32-bit words; word index = (req_addr - BASE_ADDR)[..:2].
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- LATENCY, 1: cycles from accept edge to response, legal 1..4.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; low forces all state below immediately.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; others are treated as word.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  in  32  PC of the issuing instruction.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and exceptions.
- exc_valid  out  1  with rsp_valid: request faulted.
- exc_code  out  5  4 = AdEL (load), 5 = AdES (store).
- exc_pc  out  32  req_pc of the faulting request.
- busy  out  1  init sweep in progress.

## Operation
- States: INIT, IDLE, WAIT.
- INIT
  - Entered while reset is low; the sweep runs after release.
  - Writes 0 to word cnt, cnt = 0..DEPTH_WORDS-1, one word per cycle.
  - busy = 1, req_ready = 0.
  - After the write to the last word, goes to IDLE.
- IDLE
  - req_ready = 1.
  - On accept, goes to WAIT with lat_cnt = LATENCY-1 and latches type, address lanes, pc, fault and read word.
- WAIT
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0: rsp_valid = 1 and req_ready = 1.
  - A new accept in that cycle reloads WAIT; otherwise the block returns to IDLE.
- Fault check at accept:
  - misaligned: word with addr[1:0] != 0, or half with addr[0] != 0;
  - out of range: addr < BASE_ADDR, or word index >= DEPTH_WORDS.
- Faulting request:
  - no array write; response carries exc_valid = 1, the code chosen by req_we, exc_pc = req_pc, and rsp_rdata = 0.
- Stores:
  - The array write is committed on the accept edge, using byte enables.
  - Word: all lanes enabled.
  - Half: lanes {1,0} when addr[1] = 0, lanes {3,2} when addr[1] = 1; data placed in [15:0] or [31:16].
  - Byte: lane addr[1:0]; lane k occupies bits [8k+7:8k].
  - Unselected lanes keep their previous contents.
- Loads:
  - The word is read on the accept edge, so a load sees every earlier accepted store.
  - The selected lane(s) are shifted down, then sign- or zero-extended per req_type into rsp_rdata.
- Non-response cycles: rsp_rdata, exc_valid, exc_code and exc_pc are held at 0.

## Timing
- Reset low: state = INIT, cnt = 0, lat_cnt = 0.
  - All outputs 0 except busy = 1.
  - Array contents are undefined until the sweep completes.
- Sweep latency: DEPTH_WORDS cycles after reset rises; req_ready first goes high in cycle DEPTH_WORDS.
- Request accepted at edge T: rsp_valid is high for exactly the cycle after edge T+LATENCY-1 (LATENCY=1 means the cycle right after the accept edge).
- Throughput: one request per LATENCY cycles; with LATENCY=1, back-to-back every cycle.
- req_valid with req_ready = 0: the request is not accepted; the requester holds it and it is not latched.
- Reset low mid-WAIT: the pending response is dropped (no rsp_valid) and the sweep restarts. A store that was already accepted is committed but then cleared by the sweep.
- A store followed by a load to the same word, back-to-back with LATENCY=1: the load returns the new data.
- Last word (index DEPTH_WORDS-1) is legal; index DEPTH_WORDS faults.

## Test plan
- Init sweep, DEPTH_WORDS=16: release reset → busy = 1 for 16 cycles, req_ready rises in cycle 16; loads of all 16 words return 0.
- sw 0x80FF7F01 to 0x10, then loads of address 0x10:
  - lb 0x10 → 0x00000001;
  - lb 0x13 → 0xFFFFFF80, lbu 0x13 → 0x00000080;
  - lh 0x10 → 0x00007F01;
  - lhu 0x12 → 0x000080FF.
- sb 0xAB to 0x21 over word 0x11223344 → lw 0x20 returns 0x1122AB44, other lanes intact.
- lw 0x22 → exc_valid = 1, exc_code = 4, exc_pc = req_pc, no write. sh 0x31 → code 5, memory unchanged. lw at BASE_ADDR+4·DEPTH_WORDS → code 4.
- LATENCY=3, three back-to-back loads with req_valid held high:
  - rsp_valid pulses at cycles 3, 6, 9 after the first accept;
  - req_ready is low in between.
- Reset pulled low one cycle after accepting a load (LATENCY=3) → no rsp_valid; busy = 1; the sweep restarts from word 0.
